// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between an instruction-fetch and a data requester.
// Accesses are serialised with a fixed busy latency; data bursts are bounded while fetch waits.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_done,
    output logic [15:0]           f_rdata,
    output logic                  f_err,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic                  d_done,
    output logic [15:0]           d_rdata,
    output logic                  d_err,
    output logic                  busy,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_data_in,
    input  logic [15:0]           mem_data_out
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [3:0] CntInit     = 4'(LATENCY - 1);
    localparam logic [3:0] StreakMax   = 4'(MAX_DATA_STREAK);
    localparam bit         SingleCycle = (LATENCY == 1);

    state_e                state;
    logic [3:0]            cnt;
    logic [3:0]            streak;
    logic                  owner_data;
    logic                  op_wr;
    logic                  grant_data;
    logic [ADDR_WIDTH-1:0] grant_addr;

    // Data wins ties until it has taken MAX_DATA_STREAK grants in a row over a waiting fetch.
    assign grant_data = d_req && (!f_req || (streak != StreakMax));
    assign grant_addr = grant_data ? d_addr : f_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= StIdle;
            cnt         <= 4'd0;
            streak      <= 4'd0;
            owner_data  <= 1'b0;
            op_wr       <= 1'b0;
            f_done      <= 1'b0;
            f_rdata     <= 16'h0000;
            f_err       <= 1'b0;
            d_done      <= 1'b0;
            d_rdata     <= 16'h0000;
            d_err       <= 1'b0;
            busy        <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= 16'h0000;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (f_req || d_req) begin
                        owner_data <= grant_data;
                        op_wr      <= grant_data && d_wr;
                        mem_addr   <= grant_addr;
                        busy       <= 1'b1;
                        streak     <= (grant_data && f_req) ? streak + 4'd1 : 4'd0;
                        if (grant_data) begin
                            mem_data_in <= d_wdata;
                        end
                        if (grant_addr[0]) begin
                            // Misaligned: report straight away, memory is never touched.
                            state <= StDone;
                            if (grant_data) begin
                                d_done  <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= 16'h0000;
                            end else begin
                                f_done  <= 1'b1;
                                f_err   <= 1'b1;
                                f_rdata <= 16'h0000;
                            end
                        end else begin
                            state      <= StBusy;
                            cnt        <= CntInit;
                            mem_enable <= 1'b1;
                            mem_wr     <= grant_data && d_wr && SingleCycle;
                        end
                    end
                end
                StBusy: begin
                    // Strobe the write only in the last busy cycle so a store gives one write edge.
                    mem_wr <= op_wr && (cnt == 4'd1);
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= StDone;
                        mem_enable <= 1'b0;
                        if (owner_data) begin
                            d_done <= 1'b1;
                            d_err  <= 1'b0;
                            if (!op_wr) begin
                                d_rdata <= mem_data_out;
                            end
                        end else begin
                            f_done  <= 1'b1;
                            f_err   <= 1'b0;
                            f_rdata <= mem_data_out;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LATENCY 2, 1, 3), each with a memory and a
// transaction-level reference model compared every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int N         = 3;
    localparam int MaxStreak = 4;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } dcmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst_n, f_req, d_req, d_wr;
    logic [N-1:0] f_done, f_err, d_done, d_err, busy, mem_enable, mem_wr;
    logic [15:0]  f_addr [N];
    logic [15:0]  d_addr [N];
    logic [15:0]  d_wdata [N];
    logic [15:0]  f_rdata [N];
    logic [15:0]  d_rdata [N];
    logic [15:0]  mem_addr [N];
    logic [15:0]  mem_data_in [N];
    logic [15:0]  mem_data_out [N];

    // Model predictions
    logic [N-1:0] e_busy, e_men, e_mwr, e_fdone, e_ddone, e_ferr, e_derr;
    logic [15:0]  e_frd [N];
    logic [15:0]  e_drd [N];
    logic [15:0]  e_maddr [N];
    logic [15:0]  e_mdin [N];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  started = 1'b0;
    int  cyc = 0;

    function automatic void check(input string name, input int k, input logic [15:0] act,
                                  input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [inst %0d] at %0t: got %h, expected %h", name, k, $time, act, exp);
        end
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int Lat = (g == 0) ? 2 : ((g == 1) ? 1 : 3);

        logic [15:0] mem [256];
        logic [15:0] mm [256];

        mem_port_arbiter #(
            .ADDR_WIDTH      (16),
            .LATENCY         (Lat),
            .MAX_DATA_STREAK (MaxStreak)
        ) u_dut (
            .clk          (clk),
            .rst          (rst_n[g]),
            .f_req        (f_req[g]),
            .f_addr       (f_addr[g]),
            .f_done       (f_done[g]),
            .f_rdata      (f_rdata[g]),
            .f_err        (f_err[g]),
            .d_req        (d_req[g]),
            .d_wr         (d_wr[g]),
            .d_addr       (d_addr[g]),
            .d_wdata      (d_wdata[g]),
            .d_done       (d_done[g]),
            .d_rdata      (d_rdata[g]),
            .d_err        (d_err[g]),
            .busy         (busy[g]),
            .mem_enable   (mem_enable[g]),
            .mem_wr       (mem_wr[g]),
            .mem_addr     (mem_addr[g]),
            .mem_data_in  (mem_data_in[g]),
            .mem_data_out (mem_data_out[g])
        );

        initial begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = 16'h1000 + 16'(i);
                mm[i]  = 16'h1000 + 16'(i);
            end
            mem[8] = 16'hBEEF;
            mm[8]  = 16'hBEEF;
        end

        assign mem_data_out[g] = mem[mem_addr[g][8:1]];
        always @(posedge clk) begin
            if (mem_wr[g]) mem[mem_addr[g][8:1]] <= mem_data_in[g];
        end

        // Transaction model: phase counts cycles since the grant edge; tot is the done cycle.
        logic        act = 1'b0, own_d = 1'b0, wr = 1'b0, ali = 1'b0, fin;
        logic        ferr = 1'b0, derr = 1'b0;
        logic [15:0] addr = '0, wdata = '0, frd = '0, drd = '0;
        int          ph = 0, tot = 0, streak = 0;

        always @(posedge clk or negedge rst_n[g]) begin
            fin = 1'b0;
            if (!rst_n[g]) begin
                act = 1'b0; own_d = 1'b0; wr = 1'b0; ali = 1'b0; ferr = 1'b0; derr = 1'b0;
                addr = '0; wdata = '0; frd = '0; drd = '0; ph = 0; tot = 0; streak = 0;
            end else if (act) begin
                if (ph == tot) begin
                    act = 1'b0;
                end else begin
                    ph++;
                    fin = (ph == tot);
                end
            end else if (f_req[g] || d_req[g]) begin
                own_d  = d_req[g] && (!f_req[g] || streak != MaxStreak);
                streak = (own_d && f_req[g]) ? streak + 1 : 0;
                addr   = own_d ? d_addr[g] : f_addr[g];
                wr     = own_d && d_wr[g];
                if (own_d) wdata = d_wdata[g];
                ali = !addr[0];
                tot = ali ? Lat + 1 : 1;
                ph  = 1;
                act = 1'b1;
                fin = (tot == 1);
            end
            if (fin) begin
                if (!ali) begin
                    if (own_d) begin derr = 1'b1; drd = '0; end
                    else begin ferr = 1'b1; frd = '0; end
                end else if (own_d) begin
                    derr = 1'b0;
                    if (wr) mm[addr[8:1]] = wdata;
                    else drd = mm[addr[8:1]];
                end else begin
                    ferr = 1'b0;
                    frd  = mm[addr[8:1]];
                end
            end
        end

        assign e_busy[g]  = act;
        assign e_men[g]   = act && ali && (ph <= Lat);
        assign e_mwr[g]   = act && ali && wr && (ph == Lat);
        assign e_fdone[g] = act && !own_d && (ph == tot);
        assign e_ddone[g] = act && own_d && (ph == tot);
        assign e_ferr[g]  = ferr;
        assign e_derr[g]  = derr;
        assign e_frd[g]   = frd;
        assign e_drd[g]   = drd;
        assign e_maddr[g] = addr;
        assign e_mdin[g]  = wdata;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < N; k++) begin
                check("busy", k, 16'(busy[k]), 16'(e_busy[k]));
                check("mem_enable", k, 16'(mem_enable[k]), 16'(e_men[k]));
                check("mem_wr", k, 16'(mem_wr[k]), 16'(e_mwr[k]));
                check("f_done", k, 16'(f_done[k]), 16'(e_fdone[k]));
                check("d_done", k, 16'(d_done[k]), 16'(e_ddone[k]));
                check("f_rdata", k, f_rdata[k], e_frd[k]);
                check("d_rdata", k, d_rdata[k], e_drd[k]);
                if (e_fdone[k]) check("f_err", k, 16'(f_err[k]), 16'(e_ferr[k]));
                if (e_ddone[k]) check("d_err", k, 16'(d_err[k]), 16'(e_derr[k]));
                if (e_men[k]) check("mem_addr", k, mem_addr[k], e_maddr[k]);
                if (e_mwr[k]) check("mem_data_in", k, mem_data_in[k], e_mdin[k]);
            end
        end
    end

    // Event counters and done-order log for one selected instance
    int          wr_cnt [N];
    int          en_cnt [N];
    int          ddone_cnt [N];
    int          mon_k = 0;
    int          ord_n = 0;
    logic [15:0] ord_bits = '0;
    int          t_q[$];

    initial begin
        for (int k = 0; k < N; k++) begin
            wr_cnt[k] = 0; en_cnt[k] = 0; ddone_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (mem_wr[k] === 1'b1) wr_cnt[k]++;
            if (mem_enable[k] === 1'b1) en_cnt[k]++;
            if (d_done[k] === 1'b1) ddone_cnt[k]++;
        end
        if (f_done[mon_k] === 1'b1 || d_done[mon_k] === 1'b1) begin
            if (f_done[mon_k] === 1'b1 && ord_n < 16) ord_bits[ord_n] = 1'b1;
            ord_n++;
            t_q.push_back(cyc);
        end
    end

    // Requester agents: hold req until done, chain the next queued command without a gap
    logic [15:0] f_q[$];
    dcmd_t       d_q[$];
    int          f_lat, d_lat;
    logic [15:0] f_last_rd, d_last_rd;
    logic        f_last_err, d_last_err;

    task automatic wait_done(input int k, input bit is_d);
        int  n = 0;
        bit  seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = is_d ? d_done[k] : f_done[k];
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done timeout [inst %0d] %s: got no done, expected one within 40", k,
                     is_d ? "data" : "fetch");
        end else if (is_d) begin
            d_lat = n; d_last_rd = d_rdata[k]; d_last_err = d_err[k];
        end else begin
            f_lat = n; f_last_rd = f_rdata[k]; f_last_err = f_err[k];
        end
    endtask

    task automatic fetch_agent(input int k);
        while (f_q.size() != 0) begin
            f_addr[k] = f_q.pop_front();
            f_req[k]  = 1'b1;
            wait_done(k, 1'b0);
        end
        f_req[k] = 1'b0;
    endtask

    task automatic data_agent(input int k);
        dcmd_t c;
        while (d_q.size() != 0) begin
            c = d_q.pop_front();
            d_wr[k]    = c.wr;
            d_addr[k]  = c.addr;
            d_wdata[k] = c.wdata;
            d_req[k]   = 1'b1;
            wait_done(k, 1'b1);
        end
        d_req[k] = 1'b0;
    endtask

    task automatic run_both(input int k);
        fork
            fetch_agent(k);
            data_agent(k);
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [3:0] pat_en, pat_dn, pat_bz;
    int         w0, e0, w1, w2, dd2;

    initial begin
        rst_n = '0; f_req = '0; d_req = '0; d_wr = '0;
        for (int k = 0; k < N; k++) begin
            f_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        @(negedge clk);
        started = 1'b1;
        for (int k = 0; k < N; k++) begin
            check("reset busy", k, 16'(busy[k]), 16'h0);
            check("reset mem_enable", k, 16'(mem_enable[k]), 16'h0);
            check("reset f_rdata", k, f_rdata[k], 16'h0);
            check("reset d_rdata", k, d_rdata[k], 16'h0);
            check("reset mem_addr", k, mem_addr[k], 16'h0);
            check("reset mem_data_in", k, mem_data_in[k], 16'h0);
        end
        @(negedge clk);
        rst_n = '1;

        // Fetch read, LATENCY=2
        @(negedge clk);
        f_req[0] = 1'b1;
        f_addr[0] = 16'h0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pat_en[c] = mem_enable[0];
            pat_dn[c] = f_done[0];
            pat_bz[c] = busy[0];
            if (f_done[0]) begin
                f_req[0] = 1'b0;
                check("t1 f_rdata", 0, f_rdata[0], 16'hBEEF);
                check("t1 f_err", 0, 16'(f_err[0]), 16'h0);
            end
        end
        f_req[0] = 1'b0;
        check("t1 mem_enable cycles", 0, 16'(pat_en), 16'h0003);
        check("t1 f_done cycle", 0, 16'(pat_dn), 16'h0004);
        check("t1 busy cycles", 0, 16'(pat_bz), 16'h0007);

        // Store then load
        w0 = wr_cnt[0];
        d_q.push_back('{wr: 1'b1, addr: 16'h0020, wdata: 16'h1234});
        d_q.push_back('{wr: 1'b0, addr: 16'h0020, wdata: 16'h0000});
        data_agent(0);
        repeat (2) @(negedge clk);
        check("t2 write cycles", 0, 16'(wr_cnt[0] - w0), 16'd1);
        check("t2 load data", 0, d_last_rd, 16'h1234);
        check("t2 f_rdata kept", 0, f_rdata[0], 16'hBEEF);

        // Misaligned data access
        e0 = en_cnt[0];
        d_q.push_back('{wr: 1'b0, addr: 16'h0021, wdata: 16'h0000});
        data_agent(0);
        repeat (2) @(negedge clk);
        check("t3 done latency", 0, 16'(d_lat), 16'd1);
        check("t3 d_err", 0, 16'(d_last_err), 16'h1);
        check("t3 d_rdata", 0, d_last_rd, 16'h0000);
        check("t3 enable cycles", 0, 16'(en_cnt[0] - e0), 16'd0);

        // Starvation guard: both held; expect D,D,D,D,F,D,D,D,D,F
        mon_k = 0; ord_n = 0; ord_bits = '0; t_q.delete();
        f_q.push_back(16'h0010);
        f_q.push_back(16'h0012);
        for (int i = 0; i < 8; i++) d_q.push_back('{wr: 1'b0, addr: 16'h0030 + 16'(2 * i),
                                                   wdata: 16'h0000});
        run_both(0);
        repeat (2) @(negedge clk);
        check("t4 grant count", 0, 16'(ord_n), 16'd10);
        check("t4 grant order (1=F)", 0, ord_bits, 16'h0210);
        check("t4 last fetch data", 0, f_rdata[0], 16'h1009);
        check("t4 last load data", 0, d_rdata[0], 16'h101F);

        // Contention with LATENCY=1: order D,D,D,D,F,D,F, 3 cycles apart
        mon_k = 1; ord_n = 0; ord_bits = '0; t_q.delete();
        w1 = wr_cnt[1];
        f_q.push_back(16'h0010);
        f_q.push_back(16'h0012);
        for (int i = 0; i < 5; i++) d_q.push_back('{wr: 1'b1, addr: 16'h0040 + 16'(2 * i),
                                                   wdata: 16'hA000 + 16'(i)});
        run_both(1);
        repeat (2) @(negedge clk);
        check("t5 grant count", 1, 16'(ord_n), 16'd7);
        check("t5 grant order (1=F)", 1, ord_bits, 16'h0050);
        for (int i = 1; i < t_q.size(); i++) begin
            check("t5 done spacing", 1, 16'(t_q[i] - t_q[i-1]), 16'd3);
        end
        check("t5 write cycles", 1, 16'(wr_cnt[1] - w1), 16'd5);
        check("t5 last stored word", 1, g_inst[1].mem[8'h24], 16'hA004);
        check("t5 fetch data", 1, f_rdata[1], 16'h1009);

        // Reset during the first busy cycle of a store, LATENCY=3
        w2 = wr_cnt[2];
        dd2 = ddone_cnt[2];
        @(negedge clk);
        d_req[2] = 1'b1; d_wr[2] = 1'b1; d_addr[2] = 16'h0030; d_wdata[2] = 16'h5555;
        @(posedge clk);
        #1;
        check("t6 busy before reset", 2, 16'(busy[2]), 16'h1);
        check("t6 enable before reset", 2, 16'(mem_enable[2]), 16'h1);
        #1;
        rst_n[2] = 1'b0;
        d_req[2] = 1'b0;
        #1;
        check("t6 busy after reset", 2, 16'(busy[2]), 16'h0);
        check("t6 enable after reset", 2, 16'(mem_enable[2]), 16'h0);
        check("t6 mem_wr after reset", 2, 16'(mem_wr[2]), 16'h0);
        check("t6 mem_addr after reset", 2, mem_addr[2], 16'h0);
        check("t6 mem_data_in after reset", 2, mem_data_in[2], 16'h0);
        repeat (4) @(negedge clk);
        check("t6 no d_done", 2, 16'(ddone_cnt[2] - dd2), 16'd0);
        check("t6 no write", 2, 16'(wr_cnt[2] - w2), 16'd0);
        check("t6 memory intact", 2, g_inst[2].mem[8'h18], 16'h1018);
        rst_n[2] = 1'b1;
        f_q.push_back(16'h0010);
        fetch_agent(2);
        check("t6 fetch latency", 2, 16'(f_lat), 16'd4);
        check("t6 fetch data", 2, f_last_rd, 16'hBEEF);
        check("t6 fetch err", 2, 16'(f_last_err), 16'h0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares one single-port, byte-addressable, 16-bit memory between an instruction-fetch requester and a data (load/store) requester. It sits between the fetch/memory pipeline stages and the memory macro. It serialises accesses, since the memory allows no concurrent read and write. It models a configurable multi-cycle access latency, rejects misaligned addresses, and guarantees fetch forward progress under sustained data traffic.

## Interface
- ADDR_WIDTH, 16, address width of both requesters and the memory port
- LATENCY, 2, memory busy cycles per access; legal range 1..15
- MAX_DATA_STREAK, 4, consecutive data grants allowed while fetch waits; legal range 1..15
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- f_req  in  1  fetch request; held until f_done
- f_addr  in  ADDR_WIDTH  fetch byte address
- f_done  out  1  one-cycle pulse: fetch complete, f_rdata/f_err valid
- f_rdata  out  16  fetch read data, held until next f_done
- f_err  out  1  misaligned fetch; valid with f_done
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  16  store data
- d_done  out  1  one-cycle pulse: data op complete
- d_rdata  out  16  load data, held until next d_done
- d_err  out  1  misaligned data access; valid with d_done
- busy  out  1  high in any non-IDLE state
- mem_enable  out  1  memory enable
- mem_wr  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address (registered)
- mem_data_in  out  16  memory write data (registered)
- mem_data_out  in  16  memory combinational read data

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: arbitrate if f_req or d_req.
  - Only one request: grant it.
  - Both requesting: grant data, unless streak == MAX_DATA_STREAK, in which case grant fetch.
  - Streak increments on each data grant made while f_req is high. It clears on any fetch grant, and on a data grant made with f_req low.
- On grant: latch owner, addr, wr (fetch forces wr=0), and wdata.
  - If addr[0]=1, no memory access occurs. Go to DONE with err=1 and rdata=0.
  - Otherwise go to BUSY with cnt=LATENCY-1.
- BUSY:
  - mem_enable=1 throughout.
  - mem_wr=1 only in the final BUSY cycle (cnt==0), so each store produces exactly one write edge.
  - Decrement cnt each cycle.
  - At cnt==0, capture mem_data_out into the owner's rdata (loads and fetches only) and go to DONE.
- DONE:
  - Pulse the owner's done for one cycle, with err valid; then go to IDLE.
  - Requests are not sampled in DONE.
  - If the requester keeps req high after done, the next IDLE treats it as a new transaction.
- rdata of the non-owner is never modified. A store leaves d_rdata unchanged.
- Requester inputs (addr/wr/wdata) are ignored after the grant edge.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, streak=0. All outputs are 0: done, err, rdata, busy, mem_enable, mem_wr, mem_addr, mem_data_in.
- Reset asserted mid-BUSY: abort immediately. No write occurs after reset assertion and no done pulse is issued.
- Aligned access, req sampled at edge E0:
  - BUSY occupies cycles 1..LATENCY.
  - done is high in cycle LATENCY+1.
  - Next grant is possible at edge E(LATENCY+2).
  - Throughput is one access per LATENCY+2 cycles.
- Misaligned access: done is high in cycle 1 (2-cycle turnaround). mem_enable stays 0.
- mem_enable=0 and mem_wr=0 in IDLE and DONE.
- Simultaneous f_req/d_req: resolved only in IDLE, per the streak rule. The losing request stays pending and is not dropped.

## Test plan
- Fetch read, LATENCY=2, memory word at byte address 0x0010 = 0xBEEF: f_req with f_addr=0x0010. Required: mem_enable high for 2 cycles, f_done in cycle 3, f_rdata=0xBEEF, f_err=0, busy low in cycle 4.
- Store then load: store d_addr=0x0020, d_wdata=0x1234, then load d_addr=0x0020. Required: exactly one mem_wr cycle; load returns d_rdata=0x1234; f_rdata unchanged.
- Misaligned access: d_addr=0x0021. Required: d_done the cycle after the grant, d_err=1, d_rdata=0, mem_enable never asserted.
- Starvation guard, MAX_DATA_STREAK=4: d_req and f_req both held high continuously. Required: grant order D,D,D,D,F,D,D,D,D,F; each done pulse is one cycle.
- Contention with LATENCY=1: both requesters high. Required: back-to-back accesses 3 cycles apart; mem_wr never high during a fetch.
- Reset mid-store: deassert rst during the first BUSY cycle of a store with LATENCY=3. Required: outputs zero immediately, no mem_wr pulse, no d_done. After release, a new f_req completes normally.
